// File: rtl/multi_channel_timer_pkg.sv
// Shared definitions for the multi-channel timer: default sizing,
// channel state encoding and prescaler width helper.
package multi_channel_timer_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_COUNT_W  = 24;
  localparam int DEF_PRESCALE = 50;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  // Prescaler counter width; a divide-by-1 still needs a 1-bit register.
  function automatic int pre_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/multi_channel_timer_if.sv
// Control/status bundle between a timer user (master) and the timer (slave).
interface multi_channel_timer_if
  import multi_channel_timer_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int COUNT_W = DEF_COUNT_W
);

  logic                        enable;
  logic [NUM_CH-1:0]           start;
  logic [NUM_CH-1:0]           stop;
  logic [NUM_CH-1:0]           periodic;
  logic [NUM_CH*COUNT_W-1:0]   load_val;
  logic [NUM_CH-1:0]           busy;
  logic [NUM_CH-1:0]           done;
  logic [NUM_CH*COUNT_W-1:0]   count_out;

  modport master (
    output enable, start, stop, periodic, load_val,
    input  busy, done, count_out
  );

  modport slave (
    input  enable, start, stop, periodic, load_val,
    output busy, done, count_out
  );

endinterface

// File: rtl/multi_channel_timer_channel.sv
// One timer channel: IDLE/RUN FSM with a down-counter, latched period
// and mode. Per-cycle priority is stop > start > tick.
//
//   state   | meaning
//   --------+----------------------------------------------
//   ST_IDLE | counter parked at 0, waiting for a valid start
//   ST_RUN  | counting ticks down towards expiry
module multi_channel_timer_channel
  import multi_channel_timer_pkg::*;
#(
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               sync_resetn,
  input  logic               enable,
  input  logic               tick,
  input  logic               start,
  input  logic               stop,
  input  logic               periodic,
  input  logic [COUNT_W-1:0] load_val,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] count
);

  ch_state_e          state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] period_q, period_d;
  logic               mode_q, mode_d;
  logic               done_q, done_d;
  logic               load_ok;

  assign load_ok = (load_val != '0);

  // State register; reset wins over enable.
  always_ff @(posedge clk) begin
    if (!sync_resetn) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
    end
  end

  // Next state and counter; done defaults low so it is always a single pulse.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (!stop && start && load_ok) begin
            state_d  = ST_RUN;
            count_d  = load_val;
            period_d = load_val;
            mode_d   = periodic;
          end
        end
        ST_RUN: begin
          // A start with a zero period is an abort, same as stop.
          if (stop || (start && !load_ok)) begin
            state_d = ST_IDLE;
            count_d = '0;
          end else if (start) begin
            count_d  = load_val;
            period_d = load_val;
            mode_d   = periodic;
          end else if (tick) begin
            if (count_q > COUNT_W'(1)) begin
              count_d = count_q - COUNT_W'(1);
            end else begin
              done_d = 1'b1;
              if (mode_q) begin
                count_d = period_q;
              end else begin
                state_d = ST_IDLE;
                count_d = '0;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // Outputs straight from the registers.
  always_comb begin
    busy  = (state_q == ST_RUN);
    done  = done_q;
    count = count_q;
  end

endmodule

// File: rtl/multi_channel_timer.sv
// NUM_CH independent down-counting timers sharing one free-running prescaler.
// The prescaler is never restarted by a channel start, so the first tick
// lands 1..PRESCALE cycles after a start.
module multi_channel_timer
  import multi_channel_timer_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int COUNT_W  = DEF_COUNT_W,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic                   clk,
  input  logic                   sync_resetn,
  multi_channel_timer_if.slave   bus
);

  localparam int               PRE_W   = pre_width(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (!sync_resetn) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // Prescaler wrap and common tick, both gated by the global enable.
  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (bus.enable) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    multi_channel_timer_channel #(
      .COUNT_W (COUNT_W)
    ) u_ch (
      .clk         (clk),
      .sync_resetn (sync_resetn),
      .enable      (bus.enable),
      .tick        (tick),
      .start       (bus.start[i]),
      .stop        (bus.stop[i]),
      .periodic    (bus.periodic[i]),
      .load_val    (bus.load_val[i*COUNT_W +: COUNT_W]),
      .busy        (bus.busy[i]),
      .done        (bus.done[i]),
      .count       (bus.count_out[i*COUNT_W +: COUNT_W])
    );
  end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Bench for multi_channel_timer (NUM_CH=4, COUNT_W=8, PRESCALE=2).
// A behavioural model queues the expected outputs for every cycle; a vector
// table and directed sequences add hand-derived checks.
module tb_multi_channel_timer;

  localparam int NUM_CH   = 4;
  localparam int COUNT_W  = 8;
  localparam int PRESCALE = 2;

  logic clk = 1'b0;
  logic sync_resetn;

  multi_channel_timer_if #(.NUM_CH(NUM_CH), .COUNT_W(COUNT_W)) bus ();

  multi_channel_timer #(
    .NUM_CH   (NUM_CH),
    .COUNT_W  (COUNT_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk         (clk),
    .sync_resetn (sync_resetn),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  busy;
    logic [3:0]  done;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic        rstn;
    logic [3:0]  start;
    logic [31:0] ld;
    logic [3:0]  e_busy;
    logic [3:0]  e_done;
    logic [31:0] e_cnt;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[14];
  int   total = 0;
  int   bad   = 0;

  int   m_pre;
  int   m_cnt  [4];
  bit   m_run  [4];
  int   m_per  [4];
  bit   m_mode [4];
  bit   m_done [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, using the currently driven inputs.
  function automatic void model_step();
    bit tk;
    int ld;
    if (!sync_resetn) begin
      m_pre = 0;
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0; m_run[i] = 0; m_per[i] = 0; m_mode[i] = 0; m_done[i] = 0;
      end
    end else if (!bus.enable) begin
      for (int i = 0; i < 4; i++) m_done[i] = 0;
    end else begin
      tk = (m_pre == PRESCALE - 1);
      m_pre = tk ? 0 : m_pre + 1;
      for (int i = 0; i < 4; i++) begin
        ld = int'(bus.load_val[i*8 +: 8]);
        m_done[i] = 0;
        if (bus.stop[i]) begin
          m_run[i] = 0; m_cnt[i] = 0;
        end else if (bus.start[i]) begin
          if (ld != 0) begin
            m_run[i] = 1; m_cnt[i] = ld; m_per[i] = ld; m_mode[i] = bus.periodic[i];
          end else begin
            m_run[i] = 0; m_cnt[i] = 0;
          end
        end else if (m_run[i] && tk) begin
          if (m_cnt[i] > 1) m_cnt[i]--;
          else begin
            m_done[i] = 1;
            if (m_mode[i]) m_cnt[i] = m_per[i];
            else begin m_run[i] = 0; m_cnt[i] = 0; end
          end
        end
      end
    end
  endfunction

  task automatic step();
    exp_t e;
    exp_t g;
    model_step();
    for (int i = 0; i < 4; i++) begin
      e.busy[i] = m_run[i];
      e.done[i] = m_done[i];
      e.cnt[i*8 +: 8] = 8'(m_cnt[i]);
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    chk("sb_busy",  32'(bus.busy),  32'(g.busy));
    chk("sb_done",  32'(bus.done),  32'(g.done));
    chk("sb_count", bus.count_out,  g.cnt);
  endtask

  task automatic drive(input logic rstn, input logic en, input logic [3:0] st,
                       input logic [3:0] sp, input logic [3:0] pm, input logic [31:0] ld);
    sync_resetn  = rstn;
    bus.enable   = en;
    bus.start    = st;
    bus.stop     = sp;
    bus.periodic = pm;
    bus.load_val = ld;
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] st, input logic [31:0] ld,
                              input logic [3:0] eb, input logic [3:0] ed, input logic [31:0] ec);
    vec_t v;
    v.rstn = r; v.start = st; v.ld = ld; v.e_busy = eb; v.e_done = ed; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    int seen;
    int last;
    int found;
    int nd;
    logic [31:0] held;

    // Reset with start asserted, then a one-shot of 5 ticks on ch0.
    tbl[0]  = mk(1'b0, 4'hF, 32'h05050505, 4'h0, 4'h0, 32'h0);
    tbl[1]  = mk(1'b0, 4'hF, 32'h05050505, 4'h0, 4'h0, 32'h0);
    tbl[2]  = mk(1'b0, 4'hF, 32'h05050505, 4'h0, 4'h0, 32'h0);
    tbl[3]  = mk(1'b1, 4'h1, 32'h00000005, 4'h1, 4'h0, 32'h5);
    tbl[4]  = mk(1'b1, 4'h0, 32'h00000005, 4'h1, 4'h0, 32'h4);
    tbl[5]  = mk(1'b1, 4'h0, 32'h00000005, 4'h1, 4'h0, 32'h4);
    tbl[6]  = mk(1'b1, 4'h0, 32'h00000005, 4'h1, 4'h0, 32'h3);
    tbl[7]  = mk(1'b1, 4'h0, 32'h00000005, 4'h1, 4'h0, 32'h3);
    tbl[8]  = mk(1'b1, 4'h0, 32'h00000005, 4'h1, 4'h0, 32'h2);
    tbl[9]  = mk(1'b1, 4'h0, 32'h00000005, 4'h1, 4'h0, 32'h2);
    tbl[10] = mk(1'b1, 4'h0, 32'h00000005, 4'h1, 4'h0, 32'h1);
    tbl[11] = mk(1'b1, 4'h0, 32'h00000005, 4'h1, 4'h0, 32'h1);
    tbl[12] = mk(1'b1, 4'h0, 32'h00000005, 4'h0, 4'h1, 32'h0);
    tbl[13] = mk(1'b1, 4'h0, 32'h00000005, 4'h0, 4'h0, 32'h0);

    for (int k = 0; k < 14; k++) begin
      drive(tbl[k].rstn, 1'b1, tbl[k].start, 4'h0, 4'h0, tbl[k].ld);
      step();
      chk("vec_busy",  32'(bus.busy), 32'(tbl[k].e_busy));
      chk("vec_done",  32'(bus.done), 32'(tbl[k].e_done));
      chk("vec_count", bus.count_out, tbl[k].e_cnt);
    end

    // Periodic ch1, period 3 ticks = 6 cycles.
    drive(1'b1, 1'b1, 4'b0010, 4'h0, 4'b0010, 32'h00000300);
    step();
    drive(1'b1, 1'b1, 4'h0, 4'h0, 4'b0010, 32'h00000300);
    seen = 0; last = -1;
    for (int c = 1; c <= 60 && seen < 5; c++) begin
      step();
      chk("per_busy", 32'(bus.busy[1]), 32'd1);
      if (bus.done[1]) begin
        if (last >= 0) chk("per_gap", 32'(c - last), 32'd6);
        last = c;
        seen++;
      end
    end
    chk("per_count", 32'(seen), 32'd5);
    drive(1'b1, 1'b1, 4'h0, 4'b0010, 4'h0, 32'h00000300);
    step();
    chk("per_stop_busy", 32'(bus.busy[1]), 32'd0);
    drive(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 32'h00000300);
    nd = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (bus.done[1]) nd++;
    end
    chk("per_no_done", 32'(nd), 32'd0);

    // Priority on ch2: stop beats start; zero period start.
    drive(1'b1, 1'b1, 4'b0100, 4'h0, 4'h0, 32'h00060000);
    step();
    drive(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 32'h00060000);
    repeat (3) step();
    drive(1'b1, 1'b1, 4'b0100, 4'b0100, 4'h0, 32'h00060000);
    step();
    chk("pri_busy",  32'(bus.busy[2]), 32'd0);
    chk("pri_done",  32'(bus.done[2]), 32'd0);
    chk("pri_count", 32'(bus.count_out[23:16]), 32'd0);
    drive(1'b1, 1'b1, 4'b0100, 4'h0, 4'h0, 32'h00000000);
    step();
    chk("zero_idle", 32'(bus.busy[2]), 32'd0);
    drive(1'b1, 1'b1, 4'b0100, 4'h0, 4'h0, 32'h00060000);
    step();
    drive(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 32'h00060000);
    repeat (2) step();
    drive(1'b1, 1'b1, 4'b0100, 4'h0, 4'h0, 32'h00000000);
    step();
    chk("zero_run_abort", 32'(bus.busy[2]), 32'd0);

    // Restart at count=1 on ch3, then freeze with enable low.
    drive(1'b1, 1'b1, 4'b1000, 4'h0, 4'h0, 32'h04000000);
    step();
    drive(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 32'h04000000);
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      step();
      if (bus.count_out[31:24] == 8'd1) found = 1;
    end
    chk("rs_reach_one", 32'(found), 32'd1);
    drive(1'b1, 1'b1, 4'b1000, 4'h0, 4'h0, 32'h04000000);
    step();
    chk("rs_count", 32'(bus.count_out[31:24]), 32'd4);
    chk("rs_done",  32'(bus.done[3]), 32'd0);
    drive(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 32'h04000000);
    repeat (3) step();
    held = bus.count_out;
    drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 32'h04000000);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("frz_count", bus.count_out, held);
      chk("frz_done",  32'(bus.done), 32'd0);
    end
    drive(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 32'h04000000);
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      step();
      if (bus.done[3]) found = 1;
    end
    chk("frz_resume_done", 32'(found), 32'd1);

    // Simultaneous expiry on ch0 and ch2.
    drive(1'b1, 1'b1, 4'b0101, 4'h0, 4'h0, 32'h00020002);
    step();
    drive(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 32'h00020002);
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      step();
      if (bus.done != 4'h0) found = 1;
    end
    chk("cc_seen",     32'(found), 32'd1);
    chk("cc_done",     32'(bus.done), 32'h5);
    chk("cc_ch1_busy", 32'(bus.busy[1]), 32'd0);
    chk("cc_ch1_cnt",  32'(bus.count_out[15:8]), 32'd0);
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
